snake_control: RTL and testbench

Control FSM for the snake game. It drives every strobe of the snake datapath (head and body RAM loads, address stepping, pixel drawing, food placement) and supplies the pixel colour to the VGA adapter alongside the datapath's x/y/plotEn. It sequences a fixed per-tick flow:

- erase the old body
- move the head
- test for food
- shift the body RAM
- redraw the body and the food
- wait for the next tick

---
 rtl/snake_control.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_snake_control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_control.sv
`default_nettype none
// ============================================================================
// Module      : snake_control
// Description : Control FSM for the snake game. Sequences one game tick as
//               erase body -> move head -> food test -> body RAM shift ->
//               redraw body -> draw food -> wait, drives every datapath strobe
//               and supplies the VGA pixel colour.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_control #(
  parameter int INIT_LEN    = 4,
  parameter int MAX_LEN     = 64,
  parameter int TICK_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        isDead,
  input  logic        inc_length,
  output logic        ld_head,
  output logic        ld_q_def,
  output logic        inc_address,
  output logic        rst_address,
  output logic        draw_q,
  output logic        update_head,
  output logic        ld_head_into_prev,
  output logic        ld_q_into_curr,
  output logic        ld_prev_into_q,
  output logic        ld_curr_into_prev,
  output logic        draw_curr,
  output logic        food_en,
  output logic        lock,
  output logic        check_inc,
  output logic [3:0]  cnt_status,
  output logic [2:0]  dir,
  output logic [2:0]  colour,
  output logic [10:0] length,
  output logic        dead
);

  localparam int c_TICK_W = $clog2(TICK_CYCLES);

  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
  localparam logic [10:0]         c_INIT_LEN  = 11'(INIT_LEN);
  localparam logic [10:0]         c_INIT_LAST = 11'(INIT_LEN - 1);
  localparam logic [11:0]         c_MAX_LEN   = 12'(MAX_LEN);

  localparam logic [2:0] c_DIR_UP    = 3'b100;
  localparam logic [2:0] c_DIR_DOWN  = 3'b110;
  localparam logic [2:0] c_DIR_LEFT  = 3'b000;
  localparam logic [2:0] c_DIR_RIGHT = 3'b001;

  localparam logic [2:0] c_COL_ERASE = 3'b000;
  localparam logic [2:0] c_COL_BODY  = 3'b111;
  localparam logic [2:0] c_COL_FOOD  = 3'b100;

  // Every segment pass of ERASE/DRAW is one RD cycle then 16 pixel cycles;
  // every SHIFT pass is RD, LD, WR, NX.
  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_LOAD_DEF = 4'd1,
    S_WAIT     = 4'd2,
    S_ERASE_RD = 4'd3,
    S_ERASE_PX = 4'd4,
    S_MOVE     = 4'd5,
    S_CHECK    = 4'd6,
    S_PREV     = 4'd7,
    S_SH_RD    = 4'd8,
    S_SH_LD    = 4'd9,
    S_SH_WR    = 4'd10,
    S_SH_NX    = 4'd11,
    S_DRAW_RD  = 4'd12,
    S_DRAW_PX  = 4'd13,
    S_FOOD     = 4'd14,
    S_DEAD     = 4'd15
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [10:0]           r_seg;
  logic [c_TICK_W-1:0]   r_tick;
  logic [10:0]           r_len;
  logic                  r_grow;
  logic [2:0]            r_dir;
  logic [2:0]            r_pend;

  logic                  w_px_end;
  logic                  w_tick_end;
  logic                  w_seg_last;
  logic                  w_sh_last;
  logic                  w_can_grow;
  logic                  w_key_valid;
  logic [2:0]            w_key_dir;
  logic                  w_key_ok;

  // Direction that would reverse the snake onto itself.
  function automatic logic [2:0] f_opposite(input logic [2:0] d);
    case (d)
      c_DIR_UP:    f_opposite = c_DIR_DOWN;
      c_DIR_DOWN:  f_opposite = c_DIR_UP;
      c_DIR_LEFT:  f_opposite = c_DIR_RIGHT;
      default:     f_opposite = c_DIR_LEFT;
    endcase
  endfunction

  assign w_px_end   = (r_cnt == 4'd15);
  assign w_tick_end = (r_tick == c_TICK_LAST);
  assign w_seg_last = (r_seg == (r_len - 11'd1));
  // A growing snake needs one extra shift pass to open the new tail slot.
  assign w_sh_last  = (r_seg == (r_grow ? r_len : (r_len - 11'd1)));
  assign w_can_grow = ({1'b0, r_len} < c_MAX_LEN);

  assign dir    = r_dir;
  assign length = r_len;

  // Key priority resolution and reversal filter against the committed dir.
  always_comb begin
    w_key_valid = 1'b1;
    w_key_dir   = r_pend;
    if (key_up) begin
      w_key_dir = c_DIR_UP;
    end else if (key_down) begin
      w_key_dir = c_DIR_DOWN;
    end else if (key_left) begin
      w_key_dir = c_DIR_LEFT;
    end else if (key_right) begin
      w_key_dir = c_DIR_RIGHT;
    end else begin
      w_key_valid = 1'b0;
    end
    w_key_ok = w_key_valid && (w_key_dir != f_opposite(r_dir));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and Moore output decode of the registered state.
  always_comb begin
    w_next            = r_state;
    ld_head           = 1'b0;
    ld_q_def          = 1'b0;
    inc_address       = 1'b0;
    rst_address       = 1'b0;
    draw_q            = 1'b0;
    update_head       = 1'b0;
    ld_head_into_prev = 1'b0;
    ld_q_into_curr    = 1'b0;
    ld_prev_into_q    = 1'b0;
    ld_curr_into_prev = 1'b0;
    draw_curr         = 1'b0;
    food_en           = 1'b0;
    lock              = 1'b0;
    check_inc         = 1'b0;
    cnt_status        = 4'd0;
    colour            = c_COL_ERASE;
    dead              = 1'b0;
    case (r_state)
      S_INIT: begin
        ld_head     = 1'b1;
        rst_address = 1'b1;
        w_next      = S_LOAD_DEF;
      end
      S_LOAD_DEF: begin
        ld_q_def = 1'b1;
        if (r_seg == c_INIT_LAST) begin
          rst_address = 1'b1;
          w_next      = S_DRAW_RD;
        end else begin
          inc_address = 1'b1;
        end
      end
      S_WAIT: begin
        lock = 1'b1;
        if ((r_tick == '0) && isDead) begin
          w_next = S_DEAD;
        end else if (w_tick_end) begin
          w_next = S_ERASE_RD;
        end
      end
      S_ERASE_RD: begin
        w_next = S_ERASE_PX;
      end
      S_ERASE_PX: begin
        draw_q     = 1'b1;
        cnt_status = r_cnt;
        colour     = c_COL_ERASE;
        if (w_px_end) begin
          if (w_seg_last) begin
            rst_address = 1'b1;
            w_next      = S_MOVE;
          end else begin
            inc_address = 1'b1;
            w_next      = S_ERASE_RD;
          end
        end
      end
      S_MOVE: begin
        update_head = 1'b1;
        w_next      = S_CHECK;
      end
      S_CHECK: begin
        check_inc = 1'b1;
        w_next    = S_PREV;
      end
      S_PREV: begin
        ld_head_into_prev = 1'b1;
        w_next            = S_SH_RD;
      end
      S_SH_RD: begin
        w_next = S_SH_LD;
      end
      S_SH_LD: begin
        ld_q_into_curr = 1'b1;
        w_next         = S_SH_WR;
      end
      S_SH_WR: begin
        ld_prev_into_q = 1'b1;
        w_next         = S_SH_NX;
      end
      S_SH_NX: begin
        ld_curr_into_prev = 1'b1;
        if (w_sh_last) begin
          rst_address = 1'b1;
          w_next      = S_DRAW_RD;
        end else begin
          inc_address = 1'b1;
          w_next      = S_SH_RD;
        end
      end
      S_DRAW_RD: begin
        w_next = S_DRAW_PX;
      end
      S_DRAW_PX: begin
        draw_q     = 1'b1;
        cnt_status = r_cnt;
        colour     = c_COL_BODY;
        if (w_px_end) begin
          if (w_seg_last) begin
            rst_address = 1'b1;
            w_next      = S_FOOD;
          end else begin
            inc_address = 1'b1;
            w_next      = S_DRAW_RD;
          end
        end
      end
      S_FOOD: begin
        food_en    = 1'b1;
        cnt_status = r_cnt;
        colour     = c_COL_FOOD;
        if (w_px_end) begin
          w_next = S_WAIT;
        end
      end
      S_DEAD: begin
        dead = 1'b1;
      end
      default: begin
        w_next = S_INIT;
      end
    endcase
  end

  // Pixel, segment and tick counters, length/grow bookkeeping and direction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= 4'd0;
      r_seg  <= 11'd0;
      r_tick <= '0;
      r_len  <= c_INIT_LEN;
      r_grow <= 1'b0;
      r_dir  <= c_DIR_UP;
      r_pend <= c_DIR_UP;
    end else begin
      if (r_state inside {S_ERASE_PX, S_DRAW_PX, S_FOOD}) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end

      if ((r_state == S_WAIT) && !w_tick_end) begin
        r_tick <= r_tick + c_TICK_ONE;
      end else begin
        r_tick <= '0;
      end

      case (r_state)
        S_INIT: begin
          r_seg <= 11'd0;
        end
        S_LOAD_DEF: begin
          r_seg <= (r_seg == c_INIT_LAST) ? 11'd0 : (r_seg + 11'd1);
        end
        S_ERASE_PX, S_DRAW_PX: begin
          if (w_px_end) begin
            r_seg <= w_seg_last ? 11'd0 : (r_seg + 11'd1);
          end
        end
        S_SH_NX: begin
          r_seg <= w_sh_last ? 11'd0 : (r_seg + 11'd1);
        end
        default: begin
        end
      endcase

      if (r_state == S_CHECK) begin
        r_grow <= inc_length && w_can_grow;
      end else if ((r_state == S_SH_NX) && w_sh_last) begin
        r_len  <= r_len + {10'd0, r_grow};
        r_grow <= 1'b0;
      end

      if (r_state == S_MOVE) begin
        r_dir <= r_pend;
      end

      if ((r_state != S_DEAD) && w_key_ok) begin
        r_pend <= w_key_dir;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_control
// Description : Self-checking bench for snake_control: reset sequence,
//               table of per-tick scenarios, reset mid-SHIFT and death.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_control;

  localparam int INIT_LEN    = 4;
  localparam int MAX_LEN     = 5;
  localparam int TICK_CYCLES = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic        isDead = 1'b0;
  logic        inc_length = 1'b0;
  logic        ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head;
  logic        ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev;
  logic        draw_curr, food_en, lock, check_inc, dead;
  logic [3:0]  cnt_status;
  logic [2:0]  dir, colour;
  logic [10:0] length;

  snake_control #(
    .INIT_LEN   (INIT_LEN),
    .MAX_LEN    (MAX_LEN),
    .TICK_CYCLES(TICK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .isDead(isDead), .inc_length(inc_length),
    .ld_head(ld_head), .ld_q_def(ld_q_def), .inc_address(inc_address),
    .rst_address(rst_address), .draw_q(draw_q), .update_head(update_head),
    .ld_head_into_prev(ld_head_into_prev), .ld_q_into_curr(ld_q_into_curr),
    .ld_prev_into_q(ld_prev_into_q), .ld_curr_into_prev(ld_curr_into_prev),
    .draw_curr(draw_curr), .food_en(food_en), .lock(lock), .check_inc(check_inc),
    .cnt_status(cnt_status), .dir(dir), .colour(colour), .length(length), .dead(dead)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Measurements of one tick.
  int c_wait, c_cyc, c_erase, c_draw, c_food, c_incaddr, c_single, c_shift;

  typedef struct {
    logic [3:0] keys;      // {up, down, left, right}
    logic       inc;
    logic [2:0] exp_dir;
    int         exp_len;
    int         exp_cyc;
    int         exp_erase;
    int         exp_shift;
    int         exp_draw;
    int         exp_incaddr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] strobes();
    return {ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head,
            ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev,
            draw_curr, food_en, lock, check_inc};
  endfunction

  // Runs from WAIT through one full tick back into WAIT, tallying strobes.
  task automatic run_tick(input logic [3:0] keys, input logic inc);
    int guard;
    int p_idx, q_idx;
    guard = 0;
    while (!lock && guard < 3000) begin step(); guard++; end
    chk("reach_wait", lock, 1);
    c_wait = 0;
    guard  = 0;
    while (lock && guard < 100) begin c_wait++; step(); guard++; end
    {key_up, key_down, key_left, key_right} = keys;
    c_cyc = 0; c_erase = 0; c_draw = 0; c_food = 0; c_incaddr = 0; c_single = 0;
    p_idx = 0; q_idx = 0;
    while (!lock && c_cyc < 1000) begin
      if (draw_q && colour == 3'b000) c_erase++;
      if (draw_q && colour == 3'b111) c_draw++;
      if (food_en && colour == 3'b100) c_food++;
      if (inc_address) c_incaddr++;
      c_single += int'(update_head) + int'(check_inc) + int'(ld_head_into_prev) + int'(rst_address);
      if (ld_head_into_prev) p_idx = c_cyc;
      if (ld_curr_into_prev) q_idx = c_cyc;
      inc_length = check_inc ? inc : 1'b0;
      step();
      {key_up, key_down, key_left, key_right} = 4'b0000;
      c_cyc++;
    end
    inc_length = 1'b0;
    c_shift = q_idx - p_idx;
  endtask

  initial begin
    int guard, cyc, ldq, ldq_rst_idx, drawq, col111, food, rsta, ldh, n_ldc, bad;
    logic [2:0] d0;

    //                keys     inc  dir     len cyc  erase shift draw incaddr
    tbl[0] = '{4'b0000, 1'b0, 3'b100, 4, 171, 64, 16, 64,  9};
    tbl[1] = '{4'b0100, 1'b0, 3'b100, 4, 171, 64, 16, 64,  9};  // down rejected
    tbl[2] = '{4'b1010, 1'b0, 3'b100, 4, 171, 64, 16, 64,  9};  // up beats left
    tbl[3] = '{4'b0010, 1'b0, 3'b000, 4, 171, 64, 16, 64,  9};  // left accepted
    tbl[4] = '{4'b0001, 1'b0, 3'b000, 4, 171, 64, 16, 64,  9};  // right rejected
    tbl[5] = '{4'b1100, 1'b0, 3'b100, 4, 171, 64, 16, 64,  9};  // up beats down
    tbl[6] = '{4'b0000, 1'b1, 3'b100, 5, 192, 64, 20, 80, 11};  // grow 4->5
    tbl[7] = '{4'b0000, 1'b1, 3'b100, 5, 209, 80, 20, 80, 12};  // saturated

    // ---------------- reset and start-up sequence ----------------
    step();
    chk("rst_strobes", strobes(), 14'b10010000000000);
    chk("rst_colour", colour, 3'b000);
    chk("rst_cnt", cnt_status, 0);
    chk("rst_dead", dead, 0);
    chk("rst_length", length, 4);
    chk("rst_dir", dir, 3'b100);
    rst = 1'b1;
    step();
    cyc = 0; ldq = 0; ldq_rst_idx = -1; drawq = 0; col111 = 0; food = 0; rsta = 0; ldh = 0;
    while (!lock && cyc < 300) begin
      if (ld_q_def) ldq++;
      if (ld_q_def && rst_address) ldq_rst_idx = cyc;
      if (draw_q) drawq++;
      if (colour == 3'b111) col111++;
      if (food_en) food++;
      if (rst_address) rsta++;
      if (ld_head) ldh++;
      step();
      cyc++;
    end
    chk("boot_cycles", cyc, 88);
    chk("boot_ld_q_def", ldq, 4);
    chk("boot_ldq_rst_idx", ldq_rst_idx, 3);
    chk("boot_draw_q", drawq, 64);
    chk("boot_colour111", col111, 64);
    chk("boot_food_en", food, 16);
    chk("boot_rst_address", rsta, 2);
    chk("boot_ld_head", ldh, 0);
    chk("boot_length", length, 4);
    chk("boot_dir", dir, 3'b100);

    // ---------------- per-tick table ----------------
    for (int i = 0; i < 8; i++) begin
      run_tick(tbl[i].keys, tbl[i].inc);
      chk($sformatf("t%0d_wait", i), c_wait, TICK_CYCLES);
      chk($sformatf("t%0d_cycles", i), c_cyc, tbl[i].exp_cyc);
      chk($sformatf("t%0d_dir", i), dir, tbl[i].exp_dir);
      chk($sformatf("t%0d_length", i), length, tbl[i].exp_len);
      chk($sformatf("t%0d_erase", i), c_erase, tbl[i].exp_erase);
      chk($sformatf("t%0d_shift", i), c_shift, tbl[i].exp_shift);
      chk($sformatf("t%0d_draw", i), c_draw, tbl[i].exp_draw);
      chk($sformatf("t%0d_food", i), c_food, 16);
      chk($sformatf("t%0d_incaddr", i), c_incaddr, tbl[i].exp_incaddr);
      chk($sformatf("t%0d_single", i), c_single, 6);
    end

    // ---------------- reset mid-SHIFT (3rd segment) ----------------
    guard = 0;
    while (lock && guard < 100) begin step(); guard++; end
    key_left = 1'b1;
    step();
    key_left = 1'b0;
    n_ldc = 0; guard = 0;
    while (n_ldc < 3 && guard < 500) begin
      step();
      if (ld_q_into_curr) n_ldc++;
      guard++;
    end
    chk("mid_shift_reached", ld_q_into_curr, 1);
    chk("mid_shift_dir", dir, 3'b000);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_strobes", strobes(), 14'b10010000000000);
    chk("mid_rst_length", length, 4);
    chk("mid_rst_dir", dir, 3'b100);
    chk("mid_rst_colour", colour, 3'b000);

    // ---------------- death ----------------
    guard = 0;
    while (!food_en && guard < 300) begin step(); guard++; end
    chk("death_food_seen", food_en, 1);
    isDead = 1'b1;
    guard = 0;
    while (!dead && guard < 50) begin step(); guard++; end
    chk("death_dead", dead, 1);
    isDead = 1'b0;
    d0 = dir;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      if ((k % 5) == 0) {key_up, key_down, key_left, key_right} = 4'($urandom_range(1, 15));
      step();
      {key_up, key_down, key_left, key_right} = 4'b0000;
      if (strobes() != 14'd0 || dead != 1'b1 || cnt_status != 4'd0 || colour != 3'b000) bad++;
    end
    chk("death_quiet_cycles", bad, 0);
    chk("death_dir_frozen", dir, d0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("death_rst_strobes", strobes(), 14'b10010000000000);
    chk("death_rst_dead", dead, 0);
    step();
    chk("death_rst_load_def", ld_q_def, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
